// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: data width, opcodes and FSM states.
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_MOD = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC     = 2'd1,
      WAIT_MOD = 2'd2,
      DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one op at a time to an external ALU, waits for its result (bounded for mod ops)
// and holds the captured result/flags until the downstream side takes them.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int MOD_TIMEOUT = 64
) (
   input  logic              Clk,
   input  logic              Reset,
   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // In_Ready is 1 only in IDLE, Out_Valid only in DONE; Out_* hold until Out_Ready.
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_A,
   input  logic [DATA_W-1:0] In_B,
   input  logic [2:0]        In_Op,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [2:0]        ALUOp,
   input  logic [DATA_W-1:0] Result,
   input  logic              Z,
   input  logic              V,
   input  logic              C,
   input  logic              We,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Result,
   output logic              Out_Z,
   output logic              Out_V,
   output logic              Out_C,
   output logic              Out_Err,
   output state_t            state
);

   localparam int              CNT_W        = $clog2(MOD_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MOD_TIMEOUT - 1);

   state_t           state_q;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic             accept;
   logic             capture;
   logic             timeout;

   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (In_Valid) begin
               accept    = 1'b1;
               state_nxt = (In_Op == OP_MOD) ? WAIT_MOD : EXEC;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = DONE;
         end
         WAIT_MOD: begin
            // A strobe on the last allowed cycle still counts as a normal result.
            if (We) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               timeout   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (Out_Ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         A          <= '0;
         B          <= '0;
         ALUOp      <= OP_NOP;
         Out_Result <= '0;
         Out_Z      <= 1'b0;
         Out_V      <= 1'b0;
         Out_C      <= 1'b0;
         Out_Err    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (accept) begin
            cnt_q <= '0;
            A     <= In_A;
            B     <= In_B;
            ALUOp <= In_Op;
         end else if (state_q == WAIT_MOD) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         // ALUOp returns to NOP whenever the op finishes so the mod unit is released.
         if (capture) begin
            ALUOp      <= OP_NOP;
            Out_Result <= Result;
            Out_Z      <= Z;
            Out_V      <= V;
            Out_C      <= C;
            Out_Err    <= 1'b0;
         end else if (timeout) begin
            ALUOp      <= OP_NOP;
            Out_Result <= '0;
            Out_Z      <= 1'b1;
            Out_V      <= 1'b0;
            Out_C      <= 1'b0;
            Out_Err    <= 1'b1;
         end
      end
   end

   assign In_Ready  = (state_q == IDLE);
   assign Out_Valid = (state_q == DONE);
   assign state     = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: add, mod, timeout, back-pressure, boundary strobe, mid-op reset.
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        In_Valid;
   logic        In_Ready;
   logic [31:0] In_A;
   logic [31:0] In_B;
   logic [2:0]  In_Op;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUOp;
   logic [31:0] Result;
   logic        Z;
   logic        V;
   logic        C;
   logic        We;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [31:0] Out_Result;
   logic        Out_Z;
   logic        Out_V;
   logic        Out_C;
   logic        Out_Err;
   state_t      state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   alu_issue_ctrl #(.MOD_TIMEOUT(64)) dut (
      .Clk(Clk), .Reset(Reset),
      .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_A(In_A), .In_B(In_B), .In_Op(In_Op),
      .A(A), .B(B), .ALUOp(ALUOp),
      .Result(Result), .Z(Z), .V(V), .C(C), .We(We),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Result(Out_Result), .Out_Z(Out_Z), .Out_V(Out_V), .Out_C(Out_C),
      .Out_Err(Out_Err), .state(state)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b1; In_Valid = 1'b0; In_A = '0; In_B = '0; In_Op = 3'b000;
      Result = '0; Z = 1'b0; V = 1'b0; C = 1'b0; We = 1'b0; Out_Ready = 1'b0;

      // Reset state
      step(); step();
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_in_ready", 32'(In_Ready), 32'd1);
      check("rst_out_valid", 32'(Out_Valid), 32'd0);
      check("rst_a", A, 32'd0);
      check("rst_b", B, 32'd0);
      check("rst_aluop", 32'(ALUOp), 32'd0);
      check("rst_out_result", Out_Result, 32'd0);
      check("rst_out_err", 32'(Out_Err), 32'd0);
      Reset = 1'b0;
      step();
      check("post_rst_in_ready", 32'(In_Ready), 32'd1);

      // Add op 5 + 7 = 12
      In_A = 32'd5; In_B = 32'd7; In_Op = 3'b010; In_Valid = 1'b1; Result = 32'd12;
      step();
      In_Valid = 1'b0;
      check("add_state_exec", 32'(state), 32'(EXEC));
      check("add_a", A, 32'd5);
      check("add_b", B, 32'd7);
      check("add_aluop", 32'(ALUOp), 32'h2);
      check("add_in_ready_busy", 32'(In_Ready), 32'd0);
      check("add_out_valid_early", 32'(Out_Valid), 32'd0);
      step();
      check("add_out_valid", 32'(Out_Valid), 32'd1);
      check("add_out_result", Out_Result, 32'd12);
      check("add_out_err", 32'(Out_Err), 32'd0);
      check("add_aluop_done", 32'(ALUOp), 32'd0);
      check("add_a_hold", A, 32'd5);

      // Back-pressure in DONE with a new request pending
      In_A = 32'd99; In_B = 32'd1; In_Op = 3'b001; In_Valid = 1'b1; Result = 32'd55; Z = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_out_valid", 32'(Out_Valid), 32'd1);
         check("bp_out_result", Out_Result, 32'd12);
         check("bp_out_z", 32'(Out_Z), 32'd0);
         check("bp_in_ready", 32'(In_Ready), 32'd0);
         check("bp_a_hold", A, 32'd5);
      end
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;
      check("handoff_state_idle", 32'(state), 32'(IDLE));
      check("handoff_no_accept", A, 32'd5);
      check("handoff_out_valid", 32'(Out_Valid), 32'd0);
      step();
      In_Valid = 1'b0;
      check("second_accept_a", A, 32'd99);
      check("second_state_exec", 32'(state), 32'(EXEC));
      step();
      check("second_out_result", Out_Result, 32'd55);
      check("second_out_z", 32'(Out_Z), 32'd1);
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;
      Z = 1'b0;
      check("second_release", 32'(state), 32'(IDLE));

      // Mod op 17 mod 5, strobe 10 cycles after accept
      In_A = 32'd17; In_B = 32'd5; In_Op = 3'b111; In_Valid = 1'b1; Result = 32'hdead;
      step();
      In_Valid = 1'b0;
      check("mod_state_wait", 32'(state), 32'(WAIT_MOD));
      check("mod_aluop", 32'(ALUOp), 32'h7);
      for (int i = 1; i < 10; i++) begin
         step();
         check("mod_wait_aluop", 32'(ALUOp), 32'h7);
         check("mod_wait_out_valid", 32'(Out_Valid), 32'd0);
      end
      We = 1'b1; Result = 32'd2;
      step();
      We = 1'b0;
      check("mod_out_valid", 32'(Out_Valid), 32'd1);
      check("mod_out_result", Out_Result, 32'd2);
      check("mod_out_err", 32'(Out_Err), 32'd0);
      check("mod_aluop_done", 32'(ALUOp), 32'd0);
      We = 1'b1; Result = 32'd77;
      step();
      We = 1'b0;
      check("we_in_done_ignored", Out_Result, 32'd2);
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;
      check("mod_release", 32'(state), 32'(IDLE));

      // Mod op timeout: flags forced regardless of ALU inputs
      In_A = 32'd40; In_B = 32'd3; In_Op = 3'b111; In_Valid = 1'b1;
      Result = 32'h1234; Z = 1'b0; V = 1'b1; C = 1'b1;
      step();
      In_Valid = 1'b0;
      for (int i = 0; i < 63; i++) step();
      check("to_still_waiting", 32'(state), 32'(WAIT_MOD));
      check("to_out_valid_early", 32'(Out_Valid), 32'd0);
      step();
      check("to_out_valid", 32'(Out_Valid), 32'd1);
      check("to_out_err", 32'(Out_Err), 32'd1);
      check("to_out_result", Out_Result, 32'd0);
      check("to_out_z", 32'(Out_Z), 32'd1);
      check("to_out_v", 32'(Out_V), 32'd0);
      check("to_out_c", 32'(Out_C), 32'd0);
      check("to_aluop", 32'(ALUOp), 32'd0);
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;

      // Strobe on the last allowed cycle wins over timeout
      In_Op = 3'b111; In_Valid = 1'b1; V = 1'b0; C = 1'b0;
      step();
      In_Valid = 1'b0;
      for (int i = 0; i < 63; i++) step();
      check("edge_out_valid_early", 32'(Out_Valid), 32'd0);
      We = 1'b1; Result = 32'd9; V = 1'b1;
      step();
      We = 1'b0;
      check("edge_out_valid", 32'(Out_Valid), 32'd1);
      check("edge_out_result", Out_Result, 32'd9);
      check("edge_out_err", 32'(Out_Err), 32'd0);
      check("edge_out_v", 32'(Out_V), 32'd1);
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0; V = 1'b0;

      // Reset three cycles into WAIT_MOD abandons the op
      In_A = 32'd8; In_B = 32'd3; In_Op = 3'b111; In_Valid = 1'b1;
      step();
      In_Valid = 1'b0;
      step(); step(); step();
      check("pre_rst_wait", 32'(state), 32'(WAIT_MOD));
      Reset = 1'b1;
      #1;
      check("async_rst_state", 32'(state), 32'(IDLE));
      check("async_rst_aluop", 32'(ALUOp), 32'd0);
      check("async_rst_a", A, 32'd0);
      step();
      Reset = 1'b0;
      We = 1'b1; Result = 32'd5;
      for (int i = 0; i < 3; i++) begin
         step();
         check("abandon_out_valid", 32'(Out_Valid), 32'd0);
         check("abandon_state", 32'(state), 32'(IDLE));
         check("abandon_in_ready", 32'(In_Ready), 32'd1);
      end
      We = 1'b0;
      check("abandon_out_result", Out_Result, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
